// File: rtl/surf_debug_capture.sv
// Channel-select debug capture into a circular buffer; match/write 2 clk after debug_i, WB ack/err 2 clk after accept, one access in flight.
// Optional external trigger input and CTRL[16] EXT_EN when DEBUG_CAPTURE_EXT_TRIG_EN is defined.
module surf_debug_capture #(
    parameter int NCH        = 4,
    parameter int DW         = 32,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [NCH*DW-1:0]     debug_i,
`ifdef DEBUG_CAPTURE_EXT_TRIG_EN
    input  logic                  ext_trig_i,
`endif
    input  logic                  cyc_i,
    input  logic                  stb_i,
    input  logic                  we_i,
    input  logic [DEPTH_LOG2:0]   adr_i,
    input  logic [31:0]           dat_i,
    output logic [31:0]           dat_o,
    output logic                  ack_o,
    output logic                  err_o,
    output logic                  armed_o,
    output logic                  done_o,
    output logic                  trig_o
);
    localparam int AW = DEPTH_LOG2;
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW-1:0] PTR_MAX = '1;

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_POST, S_DONE} state_t;

    state_t          state_q;
    logic [AW-1:0]   wptr_q, cnt_q, post_q, taddr_q;
    logic [7:0]      sel_q;
    logic [DW-1:0]   value_q, mask_q, s1_q, s2_q, ch_d, ram_q;
    logic            trigd_q, wrapped_q, ext_en_q, hit;
    logic            p1_vld_q, p1_we_q, ack_q, err_q, rd_buf_q;
    logic [AW:0]     p1_adr_q;
    logic [31:0]     p1_dat_q, rd_dat_q, rd_mux, ram_ext;
    logic [DW-1:0]   mem [1<<AW];

    logic            busy, accept, p1_buf, p1_err, reg_wr, ctrl_wr, arm_w, abort_w, cap_we;
    logic [2:0]      p1_idx;
    logic            unused_dat;

    assign unused_dat = ^p1_dat_q;

    always_comb begin
        ch_d = debug_i[DW-1:0];
        for (int k = 1; k < NCH; k++)
            if (int'(sel_q) == k) ch_d = debug_i[k*DW +: DW];
    end

`ifdef DEBUG_CAPTURE_EXT_TRIG_EN
    logic e1_q, e2_q;
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            e1_q <= 1'b0;
            e2_q <= 1'b0;
        end else begin
            e1_q <= ext_trig_i;
            e2_q <= e1_q;
        end
    end
    assign hit = (((s2_q ^ value_q) & mask_q) == '0) | (ext_en_q & e2_q);
`else
    assign hit = (((s2_q ^ value_q) & mask_q) == '0);
`endif

    assign armed_o = (state_q == S_ARMED) || (state_q == S_POST);
    assign done_o  = (state_q == S_DONE);

    // Wishbone: accept -> p1 (decode, register access, RAM address) -> ack/err
    assign busy    = p1_vld_q | ack_q | err_q;
    assign accept  = cyc_i & stb_i & ~busy;
    assign p1_buf  = p1_adr_q[AW];
    assign p1_idx  = p1_adr_q[2:0];
    assign p1_err  = p1_buf ? (p1_we_q | armed_o) : (p1_idx > 3'd4);
    assign reg_wr  = p1_vld_q & p1_we_q & ~p1_buf & ~p1_err;
    assign ctrl_wr = reg_wr & (p1_idx == 3'd0);
    assign abort_w = ctrl_wr & p1_dat_q[1];
    assign arm_w   = ctrl_wr & p1_dat_q[0];
    assign trig_o  = (state_q == S_ARMED) & hit & ~arm_w & ~abort_w;
    assign cap_we  = ((state_q == S_ARMED) || ((state_q == S_POST) && (cnt_q != '0)))
                     & ~arm_w & ~abort_w;

    always_comb begin
        rd_mux = '0;
        case (p1_idx)
            3'd0: begin
                rd_mux[0]    = armed_o;
                rd_mux[2]    = trigd_q;
                rd_mux[3]    = done_o;
                rd_mux[4]    = wrapped_q;
                rd_mux[15:8] = sel_q;
                rd_mux[16]   = ext_en_q;
            end
            3'd1:    rd_mux[DW-1:0] = value_q;
            3'd2:    rd_mux[DW-1:0] = mask_q;
            3'd3:    rd_mux[AW-1:0] = post_q;
            3'd4:    rd_mux[AW-1:0] = taddr_q;
            default: rd_mux = '0;
        endcase
    end

    always_comb begin
        ram_ext = '0;
        ram_ext[DW-1:0] = ram_q;
    end
    assign dat_o = rd_buf_q ? ram_ext : rd_dat_q;
    assign ack_o = ack_q;
    assign err_o = err_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            p1_vld_q <= 1'b0;
            p1_we_q  <= 1'b0;
            p1_adr_q <= '0;
            p1_dat_q <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            rd_buf_q <= 1'b0;
            rd_dat_q <= '0;
        end else begin
            p1_vld_q <= accept;
            if (accept) begin
                p1_we_q  <= we_i;
                p1_adr_q <= adr_i;
                p1_dat_q <= dat_i;
            end
            ack_q    <= p1_vld_q & ~p1_err;
            err_q    <= p1_vld_q & p1_err;
            rd_buf_q <= p1_vld_q & ~p1_err & p1_buf & ~p1_we_q;
            rd_dat_q <= (p1_vld_q & ~p1_err & ~p1_buf & ~p1_we_q) ? rd_mux : '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (cap_we) mem[wptr_q] <= s2_q;
        ram_q <= mem[p1_adr_q[AW-1:0]];
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sel_q    <= '0;
            value_q  <= '0;
            mask_q   <= '0;
            post_q   <= '0;
            ext_en_q <= 1'b0;
            s1_q     <= '0;
            s2_q     <= '0;
        end else begin
            s1_q <= ch_d;
            s2_q <= s1_q;
            if (reg_wr) begin
                case (p1_idx)
                    3'd0: begin
                        if (!armed_o) sel_q <= p1_dat_q[15:8];
`ifdef DEBUG_CAPTURE_EXT_TRIG_EN
                        ext_en_q <= p1_dat_q[16];
`endif
                    end
                    3'd1:    value_q <= p1_dat_q[DW-1:0];
                    3'd2:    mask_q  <= p1_dat_q[DW-1:0];
                    3'd3:    post_q  <= p1_dat_q[AW-1:0];
                    default: ;
                endcase
            end
        end
    end

    // A fresh capture starts at address 0 so an unwrapped buffer's oldest sample is at 0;
    // re-arming an active capture keeps the pointer.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= S_IDLE;
            wptr_q    <= '0;
            cnt_q     <= '0;
            taddr_q   <= '0;
            trigd_q   <= 1'b0;
            wrapped_q <= 1'b0;
        end else if (abort_w) begin
            state_q <= S_IDLE;
        end else if (arm_w) begin
            state_q   <= S_ARMED;
            trigd_q   <= 1'b0;
            wrapped_q <= 1'b0;
            if (!armed_o) wptr_q <= '0;
        end else begin
            case (state_q)
                S_ARMED: begin
                    wptr_q <= wptr_q + PTR_ONE;
                    if (wptr_q == PTR_MAX) wrapped_q <= 1'b1;
                    if (hit) begin
                        taddr_q <= wptr_q;
                        cnt_q   <= post_q;
                        trigd_q <= 1'b1;
                        state_q <= S_POST;
                    end
                end
                S_POST: begin
                    if (cnt_q == '0) begin
                        state_q <= S_DONE;
                    end else begin
                        wptr_q <= wptr_q + PTR_ONE;
                        if (wptr_q == PTR_MAX) wrapped_q <= 1'b1;
                        cnt_q <= cnt_q - PTR_ONE;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_surf_debug_capture.sv
// Directed bench for surf_debug_capture (NCH=4, DW=32, DEPTH_LOG2=4); ch2 is a bench-driven counter.
module tb_surf_debug_capture;
    logic         clk_i = 1'b0;
    logic         rst_n_i;
    logic [127:0] debug_i;
    logic         cyc_i, stb_i, we_i;
    logic [4:0]   adr_i;
    logic [31:0]  dat_i, dat_o;
    logic         ack_o, err_o, armed_o, done_o, trig_o;

    int checks = 0;
    int errors = 0;

    surf_debug_capture #(.NCH(4), .DW(32), .DEPTH_LOG2(4)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .debug_i(debug_i),
        .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i), .adr_i(adr_i), .dat_i(dat_i),
        .dat_o(dat_o), .ack_o(ack_o), .err_o(err_o),
        .armed_o(armed_o), .done_o(done_o), .trig_o(trig_o)
    );

    always #5 clk_i = ~clk_i;

    logic        cnt_en = 1'b0;
    logic [31:0] fc = '0;
    initial forever begin
        @(negedge clk_i);
        if (cnt_en) fc = fc + 1;
        else fc = '0;
        debug_i = {32'hC3C3_0003, fc, 32'hC1C1_0001, 32'hC0C0_0000};
    end

    int   cyc_n = 0, trig_total = 0, trig_cyc = 0, done_cyc = 0;
    logic arm_prev = 1'b0, done_prev = 1'b0, first_arm_trig = 1'b0;
    initial forever begin
        @(posedge clk_i);
        #2;
        cyc_n++;
        if (trig_o === 1'b1) begin
            trig_total++;
            trig_cyc = cyc_n;
        end
        if (armed_o === 1'b1 && !arm_prev) first_arm_trig = trig_o;
        if (done_o === 1'b1 && !done_prev) done_cyc = cyc_n;
        arm_prev  = (armed_o === 1'b1);
        done_prev = (done_o === 1'b1);
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wb(input logic w, input logic [4:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic ak, output logic er, output int lat);
        @(posedge clk_i);
        @(negedge clk_i);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = w; adr_i = a; dat_i = d;
        rd = '0; ak = 1'b0; er = 1'b0;
        @(posedge clk_i);
        #1;
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        lat = 1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk_i);
            #1;
            lat++;
            if (ack_o === 1'b1 || err_o === 1'b1) begin
                ak = ack_o; er = err_o; rd = dat_o;
                break;
            end
        end
    endtask

    task automatic wreg(input string tag, input logic [4:0] a, input logic [31:0] d);
        logic [31:0] rd; logic ak, er; int lat;
        wb(1'b1, a, d, rd, ak, er, lat);
        chk(tag, {30'd0, ak, er}, 32'h2);
    endtask

    task automatic rreg(input logic [4:0] a, output logic [31:0] rd);
        logic ak, er; int lat;
        wb(1'b0, a, 32'd0, rd, ak, er, lat);
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 400 && done_o !== 1'b1; i++) begin
            @(posedge clk_i);
            #1;
        end
        chk(tag, {31'd0, done_o}, 32'd1);
    endtask

    initial begin
        logic [31:0] rd, t;
        logic ak, er;
        int lat, tsnap;
        rst_n_i = 1'b0; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; adr_i = '0; dat_i = '0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_ack", {31'd0, ack_o}, 32'd0);
        chk("rst_err", {31'd0, err_o}, 32'd0);
        chk("rst_armed", {31'd0, armed_o}, 32'd0);
        chk("rst_done", {31'd0, done_o}, 32'd0);
        chk("rst_trig", {31'd0, trig_o}, 32'd0);
        chk("rst_dat", dat_o, 32'd0);
        @(negedge clk_i);
        rst_n_i = 1'b1;

        wb(1'b0, 5'd0, 32'd0, rd, ak, er, lat);
        chk("ctrl_rst_ack", {31'd0, ak}, 32'd1);
        chk("ctrl_rst_val", rd, 32'd0);
        wb(1'b0, 5'd5, 32'd0, rd, ak, er, lat);
        chk("adr5_err", {30'd0, ak, er}, 32'h1);
        chk("adr5_lat", 32'(lat), 32'd2);

        // SEL beyond NCH reads back as written but samples channel 0
        wreg("sel7_wr", 5'd0, 32'h0000_0700);
        rreg(5'd0, rd);
        chk("sel7_rd", rd, 32'h0000_0700);

        // MASK=0, POST=0
        wreg("m0_post", 5'd3, 32'd0);
        tsnap = trig_total;
        wreg("m0_arm", 5'd0, 32'h0000_0701);
        repeat (4) @(posedge clk_i);
        #1;
        chk("m0_first_trig", {31'd0, first_arm_trig}, 32'd1);
        chk("m0_trig_cnt", 32'(trig_total - tsnap), 32'd1);
        chk("m0_done", {31'd0, done_o}, 32'd1);
        chk("m0_done_lat", 32'(done_cyc - trig_cyc), 32'd2);
        rreg(5'd4, rd);
        chk("m0_taddr", rd, 32'd0);
        rreg(5'd16, rd);
        chk("m0_sample_ch0", rd, 32'hC0C0_0000);

        // Capture: ch2 counter, VALUE=100, POST=3
        wreg("cap_sel", 5'd0, 32'h0000_0200);
        wreg("cap_val", 5'd1, 32'd100);
        wreg("cap_mask", 5'd2, 32'hFFFF_FFFF);
        wreg("cap_post", 5'd3, 32'd3);
        tsnap = trig_total;
        wreg("cap_arm", 5'd0, 32'h0000_0201);
        cnt_en = 1'b1;
        wait_done("cap_done");
        repeat (2) @(posedge clk_i);
        #1;
        chk("cap_trig_cnt", 32'(trig_total - tsnap), 32'd1);
        chk("cap_done_lat", 32'(done_cyc - trig_cyc), 32'd5);
        rreg(5'd4, t);
        for (int i = 0; i < 4; i++) begin
            rreg({1'b1, 4'(t + 32'(i))}, rd);
            chk("cap_buf", rd, 32'(100 + i));
        end
        rreg({1'b1, 4'(t + 32'd4)}, rd);
        chk("cap_oldest", rd, 32'd88);
        rreg(5'd0, rd);
        chk("cap_status", rd, 32'h0000_021C);

        // Wrap: many non-matching samples, then match with POST=0
        cnt_en = 1'b0;
        wreg("wr_val", 5'd1, 32'd20);
        wreg("wr_post", 5'd3, 32'd0);
        wreg("wr_arm", 5'd0, 32'h0000_0201);
        cnt_en = 1'b1;
        wait_done("wr_done");
        rreg(5'd0, rd);
        chk("wr_status", rd, 32'h0000_021C);
        rreg(5'd4, t);
        rreg({1'b1, t[3:0]}, rd);
        chk("wr_trig_sample", rd, 32'd20);
        rreg({1'b1, 4'(t + 32'd1)}, rd);
        chk("wr_oldest", rd, 32'd5);

        // Lockout while armed
        wreg("lk_val", 5'd1, 32'hDEAD_BEEF);
        wreg("lk_arm", 5'd0, 32'h0000_0201);
        wb(1'b0, 5'd16, 32'd0, rd, ak, er, lat);
        chk("lk_bufrd_err", {30'd0, ak, er}, 32'h1);
        chk("lk_bufrd_dat", rd, 32'd0);
        wreg("lk_sel_wr", 5'd0, 32'h0000_0100);
        rreg(5'd0, rd);
        chk("lk_sel_rd", rd & 32'h0000_FF0F, 32'h0000_0201);
        wreg("lk_arm_abort", 5'd0, 32'h0000_0203);
        @(posedge clk_i);
        #1;
        chk("lk_abort_armed", {31'd0, armed_o}, 32'd0);
        chk("lk_abort_done", {31'd0, done_o}, 32'd0);
        rreg(5'd0, rd);
        chk("lk_abort_ctrl", rd & 32'h0000_FF0F, 32'h0000_0200);
        wb(1'b1, 5'd19, 32'h1234_5678, rd, ak, er, lat);
        chk("bufwr_err", {30'd0, ak, er}, 32'h1);

        // Reset in the middle of an access drops it
        @(posedge clk_i);
        @(negedge clk_i);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 5'd0;
        @(posedge clk_i);
        #1;
        cyc_i = 1'b0; stb_i = 1'b0;
        rst_n_i = 1'b0;
        @(negedge clk_i);
        rst_n_i = 1'b1;
        ak = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk_i);
            #1;
            if (ack_o === 1'b1 || err_o === 1'b1) ak = 1'b1;
        end
        chk("rst_mid_noack", {31'd0, ak}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
